// File: rtl/bus_protocol_pkg.sv
// Shared definitions for the dValid/dAck byte bus.
// Contents:
//   bus_state_t   - initiator FSM states (IDLE, DRIVE, GAP)
//   BUS_DW        - default bus data width
//   BUS_MIN_VALID - earliest dValid cycle (1-based) in which dAck counts
//   BUS_MAX_VALID - last dValid cycle before the transfer times out
package bus_protocol_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } bus_state_t;

    localparam int BUS_DW        = 8;
    localparam int BUS_MIN_VALID = 2;
    localparam int BUS_MAX_VALID = 4;

endpackage

// File: rtl/bus_master.sv
// Initiator side of the dValid/dAck byte bus. Takes one byte per
// accepted upstream handshake and drives it on the bus until the target
// acks it, or until MAX_VALID dValid cycles pass without an ack.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   in_valid  in   upstream byte available
//   in_ready  out  block can accept a byte this cycle (combinational)
//   in_data   in   upstream byte
//   dValid    out  bus data valid
//   data      out  bus data, held through the transfer and afterwards
//   dAck      in   target accept pulse
//   done      out  one-cycle pulse: transfer acknowledged
//   timeout   out  one-cycle pulse: transfer dropped without ack
//   xfer_cnt  out  acknowledged transfers, wraps
//   err_cnt   out  timeouts + early acks + spurious acks, saturates at 255
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus quiet, ready for a byte
// DRIVE | dValid high, waiting for dAck; vcnt is the dValid cycle number
// GAP   | one forced dValid-low cycle after a transfer; may accept again
module bus_master
    import bus_protocol_pkg::*;
#(
    parameter int DW        = BUS_DW,
    parameter int MIN_VALID = BUS_MIN_VALID,
    parameter int MAX_VALID = BUS_MAX_VALID,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             dValid,
    output logic [DW-1:0]    data,
    input  logic             dAck,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [7:0]       err_cnt
);

    localparam int VW = $clog2(MAX_VALID + 1);

    bus_state_t state, state_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt;
    logic          dvalid_nxt;
    logic [DW-1:0] data_nxt;
    logic          done_nxt;
    logic          timeout_nxt;
    logic          xfer_inc;
    logic          err_inc;
    logic          accept;

    assign in_ready = (state != DRIVE) && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            vcnt     <= '0;
            dValid   <= 1'b0;
            data     <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            xfer_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            vcnt    <= vcnt_nxt;
            dValid  <= dvalid_nxt;
            data    <= data_nxt;
            done    <= done_nxt;
            timeout <= timeout_nxt;
            if (xfer_inc) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        vcnt_nxt    = vcnt;
        dvalid_nxt  = dValid;
        data_nxt    = data;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        xfer_inc    = 1'b0;
        err_inc     = 1'b0;

        case (state)
            IDLE, GAP: begin
                // Any ack while not driving is spurious.
                err_inc = dAck;
                if (accept) begin
                    data_nxt   = in_data;
                    dvalid_nxt = 1'b1;
                    vcnt_nxt   = VW'(1);
                    state_nxt  = DRIVE;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            DRIVE: begin
                if (dAck && (vcnt >= VW'(MIN_VALID))) begin
                    dvalid_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    xfer_inc   = 1'b1;
                    state_nxt  = GAP;
                end else if (vcnt == VW'(MAX_VALID)) begin
                    // An early ack cannot land here because MIN_VALID <= MAX_VALID.
                    dvalid_nxt  = 1'b0;
                    timeout_nxt = 1'b1;
                    err_inc     = 1'b1;
                    state_nxt   = GAP;
                end else begin
                    err_inc  = dAck;
                    vcnt_nxt = vcnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                dvalid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Initiator side of the dValid/dAck byte bus.
- Takes bytes from an upstream ready/valid stream and drives one bus transfer per byte on dValid/data.
- Ends each transfer on the target's dAck pulse, or on a 4-cycle timeout.
- Exposes completion/error pulses and counters for status registers.

Parameters:
- DW, 8, data width of in_data and data.
- MIN_VALID, 2, earliest dValid cycle (1-based) in which dAck is honoured.
- MAX_VALID, 4, last dValid cycle; no ack by then means timeout.
- CNT_W, 16, width of xfer_cnt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream byte available.
- in_ready  out  1  block can accept a byte this cycle.
- in_data  in  DW  upstream byte.
- dValid  out  1  bus data valid.
- data  out  DW  bus data.
- dAck  in  1  target accept pulse.
- done  out  1  one-cycle pulse: transfer acknowledged.
- timeout  out  1  one-cycle pulse: transfer dropped, no ack.
- xfer_cnt  out  CNT_W  acknowledged transfers, wraps modulo 2^CNT_W.
- err_cnt  out  8  timeouts + early acks + spurious acks, saturates at 255.

Behaviour:
- All outputs registered except in_ready.
- Reset (sampled at posedge) forces, at the next edge:
  - state IDLE
  - dValid=0, data=0, done=0, timeout=0
  - xfer_cnt=0, err_cnt=0
- Reset mid-transfer aborts it: the byte is lost and there is no done/timeout pulse.
- States are IDLE, DRIVE, GAP.
- in_ready = (state != DRIVE) && !reset. It is combinational from state.
- Accept: in_valid && in_ready at edge E means:
  - data <= in_data, dValid <= 1, vcnt <= 1, state <= DRIVE.
  - The first dValid cycle is E+1.
- DRIVE, in dValid cycle k (vcnt=k, 1..MAX_VALID), with dAck sampled at the edge ending the cycle:
  - dAck=1 and k>=MIN_VALID: dValid <= 0, done <= 1, xfer_cnt++, state <= GAP. dValid was high k cycles.
  - dAck=1 and k<MIN_VALID: early ack. Ignore for completion, err_cnt++, continue (vcnt++).
  - dAck=0 and k<MAX_VALID: vcnt++, stay in DRIVE.
  - dAck=0 and k=MAX_VALID: dValid <= 0, timeout <= 1, err_cnt++, byte dropped (no retry), state <= GAP.
- data is held constant for the whole DRIVE period. It retains its last value after dValid falls and never goes X after reset.
- GAP lasts one cycle (dValid=0) and guarantees a dValid rising edge per transfer.
  - in_ready=1 in GAP. An accept in GAP goes straight to DRIVE, giving back-to-back transfers separated by exactly one low cycle.
  - No accept: state <= IDLE.
- dAck=1 in IDLE or GAP is a spurious ack: err_cnt++, no other effect.
- Ack ordering: done/timeout are asserted in the cycle where dValid is first low. Ack in cycle k gives dValid low in cycle k+1.
- dValid-high length is always in [MIN_VALID, MAX_VALID] for an acked transfer, and equals MAX_VALID on timeout.
- Counters:
  - err_cnt increments by at most 1 per cycle. Early and spurious acks are mutually exclusive per cycle.
  - xfer_cnt wraps FFFF->0000.
  - err_cnt holds at FF.

Decomposition:
- Shared package bus_protocol_pkg holds:
  - enum typedef bus_state_t {IDLE, DRIVE, GAP}
  - constants BUS_MIN_VALID=2, BUS_MAX_VALID=4, BUS_DW=8. Parameter defaults reference these.
- No sub-module: FSM, vcnt and the two counters stay in one module.
- The existing bus protocol property module is bound to clk/dValid/dAck/reset/data in the bench.

Test Plan:
- Single byte: in_data=8'hA5 accepted at E, dAck high in dValid cycle 2 -> dValid high E+1..E+2, low E+3, data=A5 throughout, done at E+3, xfer_cnt=1.
- Max-length ack: dAck in cycle 4 -> dValid high 4 cycles, done 1 pulse, no timeout, err_cnt=0.
- Timeout: dAck never asserted -> dValid high exactly 4 cycles, timeout pulse in 5th cycle, err_cnt=1, xfer_cnt unchanged, next byte accepted in GAP.
- Early then valid ack: dAck in cycle 1 and cycle 3 -> err_cnt=1, dValid high 3 cycles, done=1.
- Back-to-back: 3 bytes 01,02,03 with in_valid held and ack in cycle 2 each -> dValid pattern 1,1,0,1,1,0,1,1,0, xfer_cnt=3, data stable per burst.
- Reset in DRIVE cycle 2 -> dValid=0 next edge, no done/timeout, counters 0, spurious dAck afterwards in IDLE -> err_cnt=1.
